sign32narrow: RTL and testbench
===============================

Name: sign32narrow

Overview:
- Inverse of the 16->32 immediate sign-extender: takes a 32-bit signed word and narrows it to a 16-bit signed value.
- Detects words that do not round-trip through 16-bit sign extension. Either truncates or saturates them, per a per-word mode bit.
- Used on the store/immediate-pack path. It sits between a 32-bit producer and a 16-bit consumer, with valid/ready on both sides.
- Holds a 2-entry output buffer and an 8-bit saturating overflow counter.

Parameters:
- IN_W, 32, input word width.
- OUT_W, 16, narrowed output width.
- CNT_W, 8, overflow counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  IN_W  signed word to narrow.
- in_sat  in  1  mode, sampled with in_data: 0 = truncate, 1 = saturate.
- out_valid  out  1  buffer head is valid.
- out_ready  in  1  consumer takes the head this cycle.
- out_data  out  OUT_W  narrowed value.
- out_ovf  out  1  head word did not fit in OUT_W signed.
- clr_count  in  1  synchronous clear of ovf_count.
- ovf_count  out  CNT_W  number of accepted words with overflow, saturating.

Behaviour:
- Reset (async assert, sync release):
  - Buffer empty; out_valid = 0; out_data = 0; out_ovf = 0; ovf_count = 0.
  - in_ready = 1 after reset releases.
  - Asserting reset mid-operation discards all buffered words, with no output.
- Transfers:
  - Accept on in_valid & in_ready at a rising edge.
  - Deliver on out_valid & out_ready at a rising edge.
- Fit test: fits = (in_data[31:15] all 0) or (all 1), i.e. sign-extending in_data[15:0] reproduces in_data.
- Result when fits: out_data = in_data[15:0] and ovf = 0.
- Result when it does not fit: ovf = 1, and out_data depends on mode:
  - truncate: in_data[15:0].
  - saturate: 16'h7FFF if in_data[31] = 0, else 16'h8000.
- Result is computed combinationally at acceptance and written into the buffer; no other arithmetic.
- Latency: a word accepted at edge N is presented at edge N (out_valid high in the following cycle) if the buffer was empty. Otherwise it is presented in FIFO order.
- Buffer: 2-entry FIFO, count 0..2.
  - in_ready = (count != 2). It is derived from registered state only; there is no combinational out_ready -> in_ready path.
  - out_valid = (count != 0).
  - out_data and out_ovf always show the head entry. They hold stable while out_valid & !out_ready.
- Simultaneous push and pop:
  - count = 1: count stays 1 and the new word becomes head next cycle.
  - count = 2: push impossible because in_ready = 0; pop only.
  - count = 0: pop impossible; push only.
- Counter:
  - On an accepted word with ovf = 1, ovf_count increments, saturating at 2^CNT_W-1 (255); no wrap.
  - clr_count has priority over an increment in the same cycle; result is 0.
- in_data and in_sat are ignored when in_valid = 0. X on ignored inputs must not propagate.

Decomposition:
- Shared package risc_kgp_pkg:
  - constants SAT_MAX16 = 16'h7FFF and SAT_MIN16 = 16'h8000;
  - mode encodings NARROW_TRUNC = 1'b0 and NARROW_SAT = 1'b1;
  - widths IN_W and OUT_W defaults.
- One sub-module, narrow_fifo2: generic 2-entry valid/ready FIFO of width OUT_W+1, holding {ovf, data}, with async active-low reset.
- Narrowing logic and the counter stay in the top module.

Test Plan:
- Fitting word, both modes: in_data = 32'hFFFFF555 with in_sat = 0 and then 1 -> out_data = 16'hF555, out_ovf = 0, ovf_count stays 0.
- Positive overflow: in_data = 32'h00012345.
  - in_sat = 0 -> 16'h2345, ovf = 1.
  - in_sat = 1 -> 16'h7FFF, ovf = 1.
  - ovf_count = 2 after both.
- Negative overflow: in_data = 32'hFFFF7FFF, in_sat = 1 -> 16'h8000, ovf = 1.
- Boundaries: 32'h00007FFF and 32'hFFFF8000 -> pass through, ovf = 0.
- Backpressure:
  - Setup: out_ready = 0; drive 3 words 32'h1, 32'h2, 32'h3.
  - While stalled: in_ready drops after the 2nd accept, and the 3rd is held.
  - After release: out_ready = 1 -> outputs 16'h0001, 16'h0002, 16'h0003 in order, with no loss or duplication.
  - Also cover a simultaneous push and pop at count = 1.
- Counter and reset:
  - 260 overflowing words -> ovf_count = 255.
  - clr_count together with an overflowing accept -> 0.
  - Assert rst_n low with 2 words buffered -> out_valid = 0 immediately and ovf_count = 0.

Source files
------------

// File: rtl/risc_kgp_pkg.sv
// risc_kgp_pkg: shared constants and types for the 32->16 narrowing path.
//   SAT_MAX16 / SAT_MIN16 : 16-bit signed saturation limits
//   narrow_mode_e         : per-word mode (truncate / saturate)
//   DEF_IN_W / DEF_OUT_W  : default input / output widths
package risc_kgp_pkg;

    localparam int unsigned DEF_IN_W  = 32;
    localparam int unsigned DEF_OUT_W = 16;

    localparam logic [15:0] SAT_MAX16 = 16'h7FFF;
    localparam logic [15:0] SAT_MIN16 = 16'h8000;

    typedef enum logic {
        NARROW_TRUNC = 1'b0,
        NARROW_SAT   = 1'b1
    } narrow_mode_e;

endpackage

// File: rtl/narrow_fifo2.sv
// narrow_fifo2: generic 2-entry valid/ready FIFO.
//   clk, rst_n            : clock, async active-low reset
//   wr_valid_i/wr_ready_o : write side handshake, wr_data_i payload
//   rd_valid_o/rd_ready_i : read side handshake, rd_data_o = head entry
// wr_ready_o depends only on registered occupancy (no rd_ready_i path).
module narrow_fifo2 #(
    parameter int unsigned W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_valid_i,
    output logic         wr_ready_o,
    input  logic [W-1:0] wr_data_i,
    output logic         rd_valid_o,
    input  logic         rd_ready_i,
    output logic [W-1:0] rd_data_o
);

    logic [W-1:0] mem_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         push;
    logic         pop;

    assign wr_ready_o = (count_q != 2'd2);
    assign rd_valid_o = (count_q != 2'd0);
    assign push       = wr_valid_i & wr_ready_o;
    assign pop        = rd_valid_o & rd_ready_i;
    assign rd_data_o  = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sign32narrow.sv
// sign32narrow: narrow a signed IN_W word to a signed OUT_W value.
//   clk, rst_n               : clock, async active-low reset
//   in_valid/in_ready        : producer handshake; in_data word, in_sat mode
//   out_valid/out_ready      : consumer handshake; out_data, out_ovf of head
//   clr_count                : synchronous clear of ovf_count
//   ovf_count                : saturating count of accepted overflowing words
module sign32narrow
    import risc_kgp_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned OUT_W = DEF_OUT_W,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    input  logic             clr_count,
    output logic [CNT_W-1:0] ovf_count
);

    // Bits that must all equal the result sign bit for the word to fit.
    logic [IN_W-OUT_W:0] upper;
    logic                fits;
    logic [OUT_W-1:0]    res_data;
    logic                res_ovf;
    logic                accept;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;

    assign upper   = in_data[IN_W-1:OUT_W-1];
    assign fits    = (&upper) | ~(|upper);
    assign res_ovf = ~fits;
    assign accept  = in_valid & in_ready;

    always_comb begin
        res_data = in_data[OUT_W-1:0];
        if (!fits && (narrow_mode_e'(in_sat) == NARROW_SAT)) begin
            res_data = in_data[IN_W-1] ? SAT_MIN16 : SAT_MAX16;
        end
    end

    narrow_fifo2 #(
        .W (OUT_W + 1)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid_i (in_valid),
        .wr_ready_o (in_ready),
        .wr_data_i  ({res_ovf, res_data}),
        .rd_valid_o (out_valid),
        .rd_ready_i (out_ready),
        .rd_data_o  ({out_ovf, out_data})
    );

    // Clear wins over increment; increment stops at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_count) begin
            cnt_d = '0;
        end else if (accept && res_ovf && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ovf_count = cnt_q;

endmodule

// File: tb/tb_sign32narrow.sv
module tb_sign32narrow;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_sat;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        clr_count;
    logic [7:0]  ovf_count;

    int n_checks = 0;
    int n_fails  = 0;

    sign32narrow #(
        .IN_W  (32),
        .OUT_W (16),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sat    (in_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .clr_count (clr_count),
        .ovf_count (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a word and hold it until accepted; returns 1ns after the accepting edge.
    task automatic push(input logic [31:0] d, input logic s);
        int unsigned t;
        t        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sat   = s;
        while (!in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 50) check_eq("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 'x;
        in_sat   = 1'bx;
    endtask

    task automatic push_check(input string tag, input logic [31:0] d, input logic s,
                              input logic [15:0] exp_d, input logic exp_o);
        push(d, s);
        check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check_eq({tag, "_data"},  {16'd0, out_data},  {16'd0, exp_d});
        check_eq({tag, "_ovf"},   {31'd0, out_ovf},   {31'd0, exp_o});
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 'x;
        in_sat    = 1'bx;
        out_ready = 1'b0;
        clr_count = 1'b0;
        #1;
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_data",  {16'd0, out_data},  32'd0);
        check_eq("rst_ovf",   {31'd0, out_ovf},   32'd0);
        check_eq("rst_cnt",   {24'd0, ovf_count}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single-word results; consumer always ready.
        out_ready = 1'b1;
        push_check("fit_trunc", 32'hFFFFF555, 1'b0, 16'hF555, 1'b0);
        push_check("fit_sat",   32'hFFFFF555, 1'b1, 16'hF555, 1'b0);
        check_eq("cnt_after_fit", {24'd0, ovf_count}, 32'd0);
        push_check("pos_trunc", 32'h00012345, 1'b0, 16'h2345, 1'b1);
        push_check("pos_sat",   32'h00012345, 1'b1, 16'h7FFF, 1'b1);
        check_eq("cnt_after_pos", {24'd0, ovf_count}, 32'd2);
        push_check("neg_sat",   32'hFFFF7FFF, 1'b1, 16'h8000, 1'b1);
        push_check("bnd_max",   32'h00007FFF, 1'b1, 16'h7FFF, 1'b0);
        push_check("bnd_min",   32'hFFFF8000, 1'b1, 16'h8000, 1'b0);
        check_eq("cnt_after_bnd", {24'd0, ovf_count}, 32'd3);
        @(posedge clk);
        #1;
        check_eq("drain_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: fill both entries, third word must wait.
        out_ready = 1'b0;
        push(32'h1, 1'b0);
        push(32'h2, 1'b0);
        check_eq("bp_full_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_data  = 32'h3;
        in_sat   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("bp_stall_ready", {31'd0, in_ready}, 32'd0);
        check_eq("bp_stall_valid", {31'd0, out_valid}, 32'd1);
        check_eq("bp_stall_head",  {16'd0, out_data},  32'h1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_head2",   {16'd0, out_data}, 32'h2);
        check_eq("bp_ready2",  {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        // Word 3 pushed while word 2 popped at occupancy 1.
        in_valid = 1'b0;
        in_data  = 'x;
        in_sat   = 1'bx;
        check_eq("bp_head3",   {16'd0, out_data},  32'h3);
        check_eq("bp_valid3",  {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        check_eq("bp_empty",   {31'd0, out_valid}, 32'd0);

        // Counter saturation: 3 already counted, 260 more overflows.
        for (int i = 0; i < 260; i++) begin
            push(32'h00010000 + i, i[0]);
        end
        check_eq("cnt_sat", {24'd0, ovf_count}, 32'd255);
        in_valid  = 1'b1;
        in_data   = 32'h80000000;
        in_sat    = 1'b1;
        clr_count = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        clr_count = 1'b0;
        check_eq("cnt_clr_prio", {24'd0, ovf_count}, 32'd0);
        push(32'h7FFF0000, 1'b0);
        check_eq("cnt_after_clr", {24'd0, ovf_count}, 32'd1);
        @(posedge clk);
        #1;

        // Reset with two words buffered.
        out_ready = 1'b0;
        push(32'h00020000, 1'b0);
        push(32'h00030000, 1'b0);
        check_eq("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        check_eq("pre_rst_cnt",   {24'd0, ovf_count}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_cnt",   {24'd0, ovf_count}, 32'd0);
        check_eq("mid_rst_data",  {16'd0, out_data},  32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("post_rst_ready", {31'd0, in_ready},  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
